// File: rtl/gshare_bpt_pkg.sv
// Shared datapath types for the gshare branch predictor: default geometry,
// 2-bit counter encodings and the counter reset-value helper.
package gshare_bpt_pkg;

  localparam int DEF_IDX_BITS  = 11;
  localparam int DEF_CTR_BITS  = 2;
  localparam int DEF_HIST_BITS = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr2_e;

  // Weakly-not-taken for any counter width: 2**(ctr_bits-1)-1.
  function automatic logic [15:0] ctr_reset_val(input int unsigned ctr_bits);
    logic [15:0] one_s;
    one_s = 16'd1;
    return (one_s << (ctr_bits - 32'd1)) - 16'd1;
  endfunction

endpackage

// File: rtl/bpt_gshare_if.sv
// Fetch/resolve/counter bundle between the core and the gshare predictor.
interface bpt_gshare_if #(
  parameter int HIST_BITS = gshare_bpt_pkg::DEF_HIST_BITS
);
  logic [31:0]          pc_fetch;
  logic                 fetch_valid;
  logic                 pred_fetch;
  logic [HIST_BITS-1:0] hist_fetch;
  logic                 res_enable;
  logic [31:0]          pc_res;
  logic [HIST_BITS-1:0] hist_res;
  logic                 taken_res;
  logic                 mispredict_res;
  logic [31:0]          lookup_cnt;
  logic [31:0]          mispred_cnt;

  modport bpt (
    input  pc_fetch, fetch_valid, res_enable, pc_res, hist_res, taken_res, mispredict_res,
    output pred_fetch, hist_fetch, lookup_cnt, mispred_cnt
  );

  modport core (
    output pc_fetch, fetch_valid, res_enable, pc_res, hist_res, taken_res, mispredict_res,
    input  pred_fetch, hist_fetch, lookup_cnt, mispred_cnt
  );
endinterface

// File: rtl/gshare_bpt_sat_ctr_next.sv
// Saturating up/down counter next-state logic (purely combinational).
module sat_ctr_next
  import gshare_bpt_pkg::*;
#(
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic [CTR_BITS-1:0] ctr_cur,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_nxt
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1'b1);

  // Step toward the outcome, holding at either end.
  always_comb begin
    ctr_nxt = ctr_cur;
    if (taken) begin
      if (ctr_cur == CTR_MAX) ctr_nxt = ctr_cur;
      else                    ctr_nxt = ctr_cur + CTR_ONE;
    end else begin
      if (ctr_cur == CTR_MIN) ctr_nxt = ctr_cur;
      else                    ctr_nxt = ctr_cur - CTR_ONE;
    end
  end

endmodule

// File: rtl/gshare_bpt.sv
// Gshare direction predictor: PC xor speculative global history indexes a table
// of saturating counters; resolution trains the table and repairs history.
module gshare_bpt
  import gshare_bpt_pkg::*;
#(
  parameter int IDX_BITS  = DEF_IDX_BITS,
  parameter int CTR_BITS  = DEF_CTR_BITS,
  parameter int HIST_BITS = DEF_HIST_BITS
) (
  input logic   CLK,
  input logic   RST,
  bpt_gshare_if.bpt bus
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));

  logic [CTR_BITS-1:0]  table_s [ENTRIES];
  logic [HIST_BITS-1:0] ghr_r;
  logic [HIST_BITS-1:0] ghr_nxt_s;
  logic [31:0]          lookup_cnt_r;
  logic [31:0]          mispred_cnt_r;
  logic [IDX_BITS-1:0]  fetch_idx_s;
  logic [IDX_BITS-1:0]  res_idx_s;
  logic [CTR_BITS-1:0]  ctr_cur_s;
  logic [CTR_BITS-1:0]  ctr_upd_s;
  logic                 pred_s;
  logic                 recover_s;
  logic                 unused_s;

  assign fetch_idx_s = bus.pc_fetch[IDX_BITS+1:2] ^ IDX_BITS'(ghr_r);
  assign res_idx_s   = bus.pc_res[IDX_BITS+1:2] ^ IDX_BITS'(bus.hist_res);
  assign pred_s      = table_s[fetch_idx_s][CTR_BITS-1];
  assign ctr_cur_s   = table_s[res_idx_s];
  assign recover_s   = bus.res_enable & bus.mispredict_res;
  assign unused_s    = ^{bus.pc_fetch[31:IDX_BITS+2], bus.pc_fetch[1:0],
                         bus.pc_res[31:IDX_BITS+2], bus.pc_res[1:0]};

  sat_ctr_next #(.CTR_BITS(CTR_BITS)) u_sat_ctr_next (
    .ctr_cur (ctr_cur_s),
    .taken   (bus.taken_res),
    .ctr_nxt (ctr_upd_s)
  );

  // History next state: recovery from the resolving snapshot beats a fetch shift.
  always_comb begin
    ghr_nxt_s = ghr_r;
    if (recover_s) begin
      ghr_nxt_s = HIST_BITS'({bus.hist_res, bus.taken_res});
    end else if (bus.fetch_valid) begin
      ghr_nxt_s = HIST_BITS'({ghr_r, pred_s});
    end else begin
      ghr_nxt_s = ghr_r;
    end
  end

  // History register and performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ghr_r         <= {HIST_BITS{1'b0}};
      lookup_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      ghr_r <= ghr_nxt_s;
      if (bus.fetch_valid) lookup_cnt_r <= lookup_cnt_r + 32'd1;
      if (recover_s)       mispred_cnt_r <= mispred_cnt_r + 32'd1;
    end
  end

  // One register per entry; only the resolving index is written.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic [CTR_BITS-1:0] ctr_r;

    // Counter storage for this table slot.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        ctr_r <= CTR_RST;
      end else if (bus.res_enable && (res_idx_s == IDX_BITS'(g))) begin
        ctr_r <= ctr_upd_s;
      end
    end

    assign table_s[g] = ctr_r;
  end

  assign bus.pred_fetch  = pred_s;
  assign bus.hist_fetch  = ghr_r;
  assign bus.lookup_cnt  = lookup_cnt_r;
  assign bus.mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_gshare_bpt.sv
// Scoreboard bench for gshare_bpt: a reference model pushes expected outputs
// as each cycle is driven; each scenario task pops and compares them.
module tb_gshare_bpt;

  typedef struct packed {
    logic        pred;
    logic [7:0]  hist;
    logic [31:0] lcnt;
    logic [31:0] mcnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  exp_t        exp_q[$];
  int          m_tbl [0:2047];
  logic [7:0]  m_ghr;
  logic [31:0] m_lcnt;
  logic [31:0] m_mcnt;

  bpt_gshare_if #(.HIST_BITS(8)) bus ();

  gshare_bpt dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc, input logic [7:0] h);
    return int'(pc[12:2] ^ {3'b000, h});
  endfunction

  function automatic int mupd(input int c, input logic tk);
    if (tk) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) m_tbl[i] = 1;
    m_ghr  = 8'h00;
    m_lcnt = 32'd0;
    m_mcnt = 32'd0;
    exp_q.delete();
  endtask

  // Drive one cycle at the falling edge, push what the outputs must show now,
  // then advance the model to the state after the next rising edge.
  task automatic drive(input logic fv, input logic [31:0] pf, input logic re,
                       input logic [31:0] pr, input logic [7:0] hr,
                       input logic tk, input logic mp);
    exp_t e;
    int   ri;
    logic p;
    @(negedge clk);
    bus.fetch_valid    = fv;
    bus.pc_fetch       = pf;
    bus.res_enable     = re;
    bus.pc_res         = pr;
    bus.hist_res       = hr;
    bus.taken_res      = tk;
    bus.mispredict_res = mp;
    #1;
    p      = (m_tbl[midx(pf, m_ghr)] >= 2);
    e.pred = p;
    e.hist = m_ghr;
    e.lcnt = m_lcnt;
    e.mcnt = m_mcnt;
    exp_q.push_back(e);
    if (re) begin
      ri        = midx(pr, hr);
      m_tbl[ri] = mupd(m_tbl[ri], tk);
    end
    if (re && mp) begin
      m_ghr  = {hr[6:0], tk};
      m_mcnt = m_mcnt + 32'd1;
    end else if (fv) begin
      m_ghr = {m_ghr[6:0], p};
    end
    if (fv) m_lcnt = m_lcnt + 32'd1;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [31:0] pcs [4];
    pcs[0] = 32'h0000_0100;
    pcs[1] = 32'h0000_0000;
    pcs[2] = 32'hFFFF_FFFC;
    pcs[3] = 32'h1234_5678;
    rst = 1'b1;
    bus.fetch_valid = 1'b0; bus.pc_fetch = 32'd0; bus.res_enable = 1'b0;
    bus.pc_res = 32'd0; bus.hist_res = 8'h00; bus.taken_res = 1'b0; bus.mispredict_res = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, pcs[i], 1'b0, 32'd0, 8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL reset_lookup[%0d]: got pred=%0b hist=%h lc=%0d mc=%0d want pred=%0b hist=%h lc=%0d mc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt, e.pred, e.hist, e.lcnt, e.mcnt);
      end
      if (i == 0) begin
        n_cmp++;
        if (bus.pred_fetch !== 1'b0 || bus.hist_fetch !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_pc100: got pred=%0b hist=%h want pred=0 hist=00", bus.pred_fetch, bus.hist_fetch);
        end
      end
    end
  endtask

  task automatic test_train();
    exp_t        e;
    logic [10:0] tk_seq;
    tk_seq = 11'b111_0000_1111;
    for (int i = 0; i < 12; i++) begin
      if (i < 11) drive(1'b0, 32'h100, 1'b1, 32'h100, 8'h00, tk_seq[i], 1'b0);
      else        drive(1'b0, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL train[%0d]: got pred=%0b hist=%h lc=%0d mc=%0d want pred=%0b hist=%h lc=%0d mc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt, e.pred, e.hist, e.lcnt, e.mcnt);
      end
      if (i == 2 || i == 4 || i == 6 || i == 11) begin
        n_cmp++;
        if (bus.pred_fetch !== ((i == 6) ? 1'b0 : 1'b1)) begin
          n_fail++;
          $display("FAIL train_sat[%0d]: got pred=%0b want %0b", i, bus.pred_fetch, (i == 6) ? 1'b0 : 1'b1);
        end
      end
    end
    // Entries 0x42 and 0x45 drive the taken predictions of the history test.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, (i < 2) ? 32'h108 : 32'h114, 8'h00, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL train_aux[%0d]: got pred=%0b hist=%h want pred=%0b hist=%h",
                 i, bus.pred_fetch, bus.hist_fetch, e.pred, e.hist);
      end
    end
  endtask

  task automatic test_history();
    exp_t       e;
    logic [3:0] want;
    want = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 1'b1 : 1'b0, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL history[%0d]: got pred=%0b hist=%h lc=%0d want pred=%0b hist=%h lc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, e.pred, e.hist, e.lcnt);
      end
      if (i < 4) begin
        n_cmp++;
        if (bus.pred_fetch !== want[i]) begin
          n_fail++;
          $display("FAIL history_pred[%0d]: got %0b want %0b", i, bus.pred_fetch, want[i]);
        end
      end else begin
        n_cmp++;
        if (bus.hist_fetch !== 8'h0B || bus.lookup_cnt !== 32'd4) begin
          n_fail++;
          $display("FAIL history_final: got hist=%h lc=%0d want hist=0b lc=4", bus.hist_fetch, bus.lookup_cnt);
        end
      end
    end
  endtask

  task automatic test_recover();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 32'h100, 1'b1, 32'h300, 8'h05, 1'b1, 1'b1);
        1:       drive(1'b0, 32'h100, 1'b1, 32'h300, 8'h80, 1'b0, 1'b1);
        2:       drive(1'b0, 32'h100, 1'b0, 32'h300, 8'h33, 1'b1, 1'b1);
        default: drive(1'b0, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL recover[%0d]: got pred=%0b hist=%h lc=%0d mc=%0d want pred=%0b hist=%h lc=%0d mc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt, e.pred, e.hist, e.lcnt, e.mcnt);
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.hist_fetch !== 8'h0B || bus.mispred_cnt !== 32'd1) begin
          n_fail++;
          $display("FAIL recover_override: got hist=%h mc=%0d want hist=0b mc=1", bus.hist_fetch, bus.mispred_cnt);
        end
      end
    end
  endtask

  task automatic test_same_entry();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b0, 32'h200, 1'b1, 32'h200, m_ghr, 1'b1, 1'b0);
      else        drive(1'b0, 32'h200, 1'b0, 32'h0,   8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.pred_fetch !== e.pred || bus.pred_fetch !== ((i == 0) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL same_entry[%0d]: got pred=%0b want %0b", i, bus.pred_fetch, e.pred);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] pr;
    logic [7:0]  hr;
    for (int i = 0; i < 300; i++) begin
      pr = {19'd0, 3'($urandom_range(0, 7)), 8'h00, 2'b00} | 32'h100;
      hr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : m_ghr;
      drive(1'($urandom_range(0, 1)), pr ^ {20'd0, 4'($urandom_range(0, 3)), 8'h00},
            1'($urandom_range(0, 1)), pr, hr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got pred=%0b hist=%h lc=%0d mc=%0d want pred=%0b hist=%h lc=%0d mc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt, e.pred, e.hist, e.lcnt, e.mcnt);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b0, 32'h100, 1'b1, 32'h0,   8'h01, 1'b1, 1'b1);
        1, 2, 3: drive(1'b0, 32'h100, 1'b1, 32'h100, 8'h03, 1'b1, 1'b0);
        default: drive(1'b0, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: got pred=%0b hist=%h want pred=%0b hist=%h",
                 i, bus.pred_fetch, bus.hist_fetch, e.pred, e.hist);
      end
    end
    n_cmp++;
    if (bus.pred_fetch !== 1'b1 || bus.hist_fetch !== 8'h03) begin
      n_fail++;
      $display("FAIL pre_reset_state: got pred=%0b hist=%h want pred=1 hist=03", bus.pred_fetch, bus.hist_fetch);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== 73'd0) begin
      n_fail++;
      $display("FAIL async_reset: got pred=%0b hist=%h lc=%0d mc=%0d want all 0",
               bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive((i == 0) ? 1'b1 : 1'b0, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, bus.mispred_cnt} !== e) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got pred=%0b hist=%h lc=%0d want pred=%0b hist=%h lc=%0d",
                 i, bus.pred_fetch, bus.hist_fetch, bus.lookup_cnt, e.pred, e.hist, e.lcnt);
      end
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    n_cmp  = 0;
    n_fail = 0;
    model_reset();
    test_reset();
    test_train();
    test_history();
    test_recover();
    test_same_entry();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
